// File: rtl/mul.sv
// mul: unsigned 16x16 -> 32-bit Wallace-tree multiplier.
// P is purely combinational. P_q is a copy of P registered on each rising clk.
// Partial products are reduced column by column with full and half adder cells.
// The column heights of every reduction stage are worked out at elaboration
// time, so the reduction loops unroll into a fixed adder network.
module mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  output logic [31:0] P,
  output logic [31:0] P_q
);

  localparam int W  = 16;  // operand width
  localparam int PW = 32;  // product width / number of columns

  // ------------------------------------------------------------------
  // Adder cells. Each returns {carry, sum}.
  // ------------------------------------------------------------------
  function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  function automatic logic [1:0] ha_cell(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  // ------------------------------------------------------------------
  // Reduction bookkeeping for one column holding h bits in one stage.
  // Bits are consumed in threes by full adders. A leftover pair goes to a
  // half adder, unless the column already holds only two bits; in that case
  // the half adder would not shorten the tree, so both bits pass through.
  // ------------------------------------------------------------------
  function automatic int fa_count(input int h);
    return h / 3;
  endfunction

  function automatic int ha_count(input int h);
    return (((h % 3) == 2) && (h > 2)) ? 1 : 0;
  endfunction

  function automatic int pass_count(input int h);
    return h - (3 * fa_count(h)) - (2 * ha_count(h));
  endfunction

  // Bits a column keeps for itself in the next stage: FA/HA sums and passes
  function automatic int own_count(input int h);
    return fa_count(h) + ha_count(h) + pass_count(h);
  endfunction

  // Bits a column hands to the next column up in the next stage
  function automatic int carry_count(input int h);
    return fa_count(h) + ha_count(h);
  endfunction

  typedef logic [PW-1:0][4:0] hrow_t;

  // Column heights of the raw partial-product matrix
  function automatic hrow_t init_h();
    hrow_t h;
    for (int c = 0; c < PW; c++) begin
      if (c < W) begin
        h[c] = 5'(c + 1);
      end else if (c < (2 * W) - 1) begin
        h[c] = 5'((2 * W) - 1 - c);
      end else begin
        h[c] = 5'd0;
      end
    end
    return h;
  endfunction

  // Column heights after one reduction stage. Carries leaving column 31
  // are not tracked: their weight is 2^32 and the product is below 2^32.
  function automatic hrow_t step_h(input hrow_t h);
    hrow_t n;
    for (int c = 0; c < PW; c++) begin
      if (c == 0) begin
        n[c] = 5'(own_count(int'(h[c])));
      end else begin
        n[c] = 5'(own_count(int'(h[c])) + carry_count(int'(h[c-1])));
      end
    end
    return n;
  endfunction

  function automatic int max_h(input hrow_t h);
    int m;
    m = 0;
    for (int c = 0; c < PW; c++) begin
      if (int'(h[c]) > m) begin
        m = int'(h[c]);
      end
    end
    return m;
  endfunction

  // Number of stages needed before every column holds at most two bits
  function automatic int calc_nst();
    hrow_t h;
    int    n;
    h = init_h();
    n = 0;
    for (int it = 0; it < 16; it++) begin
      if (max_h(h) > 2) begin
        h = step_h(h);
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int NST = calc_nst();

  typedef logic [NST:0][PW-1:0][4:0] hmap_t;

  // Column heights for every stage, entry 0 being the partial products
  function automatic hmap_t calc_hmap();
    hmap_t m;
    hrow_t h;
    h = init_h();
    for (int s = 0; s <= NST; s++) begin
      m[s] = h;
      h    = step_h(h);
    end
    return m;
  endfunction

  localparam hmap_t HMAP = calc_hmap();

  // ------------------------------------------------------------------
  // Datapath
  // w_col[s][c] holds the bits of column c entering stage s, packed from
  // index 0 upward. Index 32 is a sink for carries out of column 31, which
  // are always zero. Unused positions are tied to 0 so no adder input is
  // ever left undriven.
  // ------------------------------------------------------------------
  logic [W-1:0]  w_col [0:NST][0:PW];
  logic [PW-1:0] w_p;
  logic [PW-1:0] r_p_q;

  // Form the partial products and reduce them, stage by stage, to two rows
  always_comb begin
    int         h;
    int         nf;
    int         nh;
    int         np;
    int         cb;
    int         k;
    logic [1:0] fr;
    h  = 0;
    nf = 0;
    nh = 0;
    np = 0;
    cb = 0;
    k  = 0;
    fr = 2'b00;
    for (int s = 0; s <= NST; s++) begin
      for (int c = 0; c <= PW; c++) begin
        w_col[s][c] = 16'h0000;
      end
    end
    // pp[i][j] = X[j] & Y[i] lands in column i+j
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        k = ((i + j) < W) ? i : (W - 1 - j);
        w_col[0][i+j][k] = X[j] & Y[i];
      end
    end
    // In the next stage a column lists its own sums/passes first, then the
    // carries arriving from the column below; cb is where those carries start.
    for (int s = 0; s < NST; s++) begin
      for (int c = 0; c < PW; c++) begin
        h  = int'(HMAP[s][c]);
        nf = fa_count(h);
        nh = ha_count(h);
        np = pass_count(h);
        cb = ((c + 1) < PW) ? own_count(int'(HMAP[s][c+1])) : 0;
        for (int f = 0; f < nf; f++) begin
          fr = fa_cell(w_col[s][c][3*f], w_col[s][c][(3*f)+1], w_col[s][c][(3*f)+2]);
          w_col[s+1][c][f]        = fr[0];
          w_col[s+1][c+1][cb + f] = fr[1];
        end
        if (nh != 0) begin
          fr = ha_cell(w_col[s][c][3*nf], w_col[s][c][(3*nf)+1]);
          w_col[s+1][c][nf]        = fr[0];
          w_col[s+1][c+1][cb + nf] = fr[1];
        end else begin
          for (int p = 0; p < np; p++) begin
            w_col[s+1][c][nf + p] = w_col[s][c][(3*nf) + p];
          end
        end
      end
    end
  end

  // Ripple carry-propagate adder over the two remaining rows
  always_comb begin
    logic       cy;
    logic [1:0] fr;
    w_p = 32'h0000_0000;
    cy  = 1'b0;
    fr  = 2'b00;
    for (int c = 0; c < PW; c++) begin
      fr     = fa_cell(w_col[NST][c][0], w_col[NST][c][1], cy);
      w_p[c] = fr[0];
      cy     = fr[1];
    end
  end

  assign P = w_p;

  // Registered copy of the product for pipelined consumers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_q <= 32'h0000_0000;
    end else begin
      r_p_q <= w_p;
    end
  end

  assign P_q = r_p_q;

endmodule

// File: tb/tb_mul.sv
// tb_mul: directed table, random sweep and register sequences for mul.
module tb_mul;

  logic        clk;
  logic        rst_n;
  logic [15:0] X;
  logic [15:0] Y;
  logic [31:0] P;
  logic [31:0] P_q;

  int n_checks = 0;
  int n_fail   = 0;

  mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .Y     (Y),
    .P     (P),
    .P_q   (P_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] p;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (X=%04h Y=%04h)", name, act, exp, X, Y);
    end
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] ry;
    logic [31:0] rexp;

    vecs[0]  = '{"zero_x",   16'h0000, 16'hABCD, 32'h0000_0000};
    vecs[1]  = '{"ident_x",  16'h0001, 16'hABCD, 32'h0000_ABCD};
    vecs[2]  = '{"ident_y",  16'hABCD, 16'h0001, 32'h0000_ABCD};
    vecs[3]  = '{"zero_y",   16'hFFFF, 16'h0000, 32'h0000_0000};
    vecs[4]  = '{"max_max",  16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[5]  = '{"max_two",  16'hFFFF, 16'h0002, 32'h0001_FFFE};
    vecs[6]  = '{"msb_msb",  16'h8000, 16'h8000, 32'h4000_0000};
    vecs[7]  = '{"carry_ch", 16'h00FF, 16'h0101, 32'h0000_FFFF};
    vecs[8]  = '{"reg_pair", 16'h1234, 16'h5678, 32'h0626_0060};
    vecs[9]  = '{"small",    16'h0003, 16'h0005, 32'h0000_000F};
    vecs[10] = '{"pow2",     16'h0100, 16'h0100, 32'h0001_0000};
    vecs[11] = '{"alt_bits", 16'hAAAA, 16'h5555, 32'h38E3_1C72};
    vecs[12] = '{"msb_max",  16'h8000, 16'hFFFF, 32'h7FFF_8000};
    vecs[13] = '{"max_one",  16'hFFFF, 16'h0001, 32'h0000_FFFF};

    X     = 16'h0000;
    Y     = 16'h0000;
    rst_n = 1'b1;

    // Async reset before any clock edge
    #1 rst_n = 1'b0;
    #2 check32("reset_async_pq", P_q, 32'h0000_0000);

    // Combinational product, directed table (reset held low throughout)
    for (int i = 0; i < NV; i++) begin
      X = vecs[i].x;
      Y = vecs[i].y;
      #10;
      check32({"p_", vecs[i].name}, P, vecs[i].p);
    end

    // Combinational product, random pairs
    for (int i = 0; i < 2000; i++) begin
      rx   = 16'($urandom);
      ry   = 16'($urandom);
      rexp = {16'h0000, rx} * {16'h0000, ry};
      X    = rx;
      Y    = ry;
      #10;
      check32("p_random", P, rexp);
    end

    // Clock edges have passed with reset low: P_q must still be 0
    @(negedge clk);
    check32("reset_held_pq", P_q, 32'h0000_0000);

    // Release reset between edges: P_q waits for the next rising edge
    X = 16'h1234;
    Y = 16'h5678;
    #2 rst_n = 1'b1;
    #1 check32("release_wait_pq", P_q, 32'h0000_0000);
    @(posedge clk);
    #1 check32("first_capture_pq", P_q, 32'h0626_0060);

    // One-cycle latency: new inputs show on P now, on P_q after the edge
    @(negedge clk);
    X = 16'hFFFF;
    Y = 16'hFFFF;
    #1;
    check32("latency_old_pq", P_q, 32'h0626_0060);
    check32("latency_new_p", P, 32'hFFFE_0001);
    @(posedge clk);
    #1 check32("latency_cap_pq", P_q, 32'hFFFE_0001);

    // Async reset mid-run: only P_q clears, P keeps tracking X*Y
    #2 rst_n = 1'b0;
    #1;
    check32("midrun_pq", P_q, 32'h0000_0000);
    check32("midrun_p", P, 32'hFFFE_0001);
    @(posedge clk);
    #1 check32("midrun_held_pq", P_q, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    X = 16'h00FF;
    Y = 16'h0101;
    @(posedge clk);
    #1 check32("after_reset_pq", P_q, 32'h0000_FFFF);

    // Registered path over the whole table, one vector per clock
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      X = vecs[i].x;
      Y = vecs[i].y;
      @(posedge clk);
      #1 check32({"pq_", vecs[i].name}, P_q, vecs[i].p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
